// File: rtl/a_row_loader.sv
// A-operand row loader: packs LANES-wide beats into DIM-wide rows for the skew buffer.
// Optional LOAD starvation counter enabled by A_ROW_LOADER_BUBBLE_EN.
module a_row_loader #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int LANES   = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES*BITS_AB-1:0]            in_data,
  output logic signed [DIM-1:0][BITS_AB-1:0]  Ain,
  output logic [$clog2(DIM)-1:0]              Arow,
  output logic                                WrEn,
  output logic                                en,
  output logic                                busy,
  output logic                                done,
  output logic [15:0]                         bubble_cnt
);

  localparam int BEATS = DIM / LANES;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW = $clog2(DIM);
  localparam int DW = $clog2(2 * DIM);
  localparam logic [BW-1:0] BLAST = BW'(BEATS - 1);
  localparam logic [RW-1:0] RLAST = RW'(DIM - 1);
  localparam logic [DW-1:0] DLAST = DW'(2 * DIM - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_d;
  logic [BW-1:0] beat, beat_d;
  logic [RW-1:0] row, row_d;
  logic [DW-1:0] dcnt, dcnt_d;
  logic wren_d, en_d, done_d;
  logic xfer, row_end;
  logic [DIM-1:0][BITS_AB-1:0] asm_q, row_full;

  assign in_ready = (state == LOAD);
  assign xfer     = in_valid && in_ready;
  assign row_end  = xfer && (beat == BLAST);

  // Final beat bypasses the assembly buffer straight into the row.
  always_comb begin
    row_full = asm_q;
    for (int k = 0; k < LANES; k++) begin
      row_full[(BEATS-1)*LANES+k] = in_data[k*BITS_AB +: BITS_AB];
    end
  end

  always_comb begin
    state_d = state;
    beat_d  = beat;
    row_d   = row;
    dcnt_d  = dcnt;
    wren_d  = 1'b0;
    en_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD;
          beat_d  = '0;
          row_d   = '0;
          dcnt_d  = '0;
        end
      end
      LOAD: begin
        if (xfer) begin
          beat_d = row_end ? '0 : beat + BW'(1);
          if (row_end) begin
            wren_d = 1'b1;
            row_d  = row + RW'(1);
            if (row == RLAST) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // First DRAIN cycle carries the last WrEn, so en starts one later.
        if (dcnt == DLAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          dcnt_d  = '0;
        end else begin
          en_d   = 1'b1;
          dcnt_d = dcnt + DW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_d = IDLE;
      beat_d  = '0;
      row_d   = '0;
      dcnt_d  = '0;
      wren_d  = 1'b0;
      en_d    = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= '0;
      row   <= '0;
      dcnt  <= '0;
      WrEn  <= 1'b0;
      en    <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
      Arow  <= '0;
      Ain   <= '0;
    end else begin
      state <= state_d;
      beat  <= beat_d;
      row   <= row_d;
      dcnt  <= dcnt_d;
      WrEn  <= wren_d;
      en    <= en_d;
      done  <= done_d;
      busy  <= (state_d != IDLE);
      if (wren_d) begin
        Ain  <= row_full;
        Arow <= row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q <= '0;
    end else if (xfer) begin
      for (int k = 0; k < LANES; k++) begin
        asm_q[int'(beat)*LANES+k] <= in_data[k*BITS_AB +: BITS_AB];
      end
    end
  end

`ifdef A_ROW_LOADER_BUBBLE_EN
  logic [15:0] bcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= '0;
    end else if (state == IDLE && start && !abort) begin
      bcnt <= '0;
    end else if (state == LOAD && !in_valid && bcnt != 16'hFFFF) begin
      bcnt <= bcnt + 16'd1;
    end
  end

  assign bubble_cnt = bcnt;
`else
  assign bubble_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_a_row_loader.sv
// Bench for a_row_loader (DIM=8, LANES=4, BITS_AB=8).
// Table-driven load runs plus hand sequences for reset and abort.
module tb_a_row_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] in_data = '0;
  logic signed [7:0][7:0] ain;
  logic [2:0] arow;
  logic wren, en, busy, done;
  logic [15:0] bubble_cnt;

  a_row_loader #(.BITS_AB(8), .DIM(8), .LANES(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .Ain(ain),
    .Arow(arow),
    .WrEn(wren),
    .en(en),
    .busy(busy),
    .done(done),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic start;
    logic valid;
    logic [31:0] data;
    logic rdy;
    logic wr;
    logic [2:0] arow;
    logic en;
    logic done;
    logic busy;
  } vec_t;

  vec_t tbl[64];
  int ntbl;
  bit bmask[64];
  int passed = 0;
  int total = 0;

`ifdef A_ROW_LOADER_BUBBLE_EN
  localparam int BUB_EXP = 5;
`else
  localparam int BUB_EXP = 0;
`endif

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] beat_data(input int j, input int off);
    logic [31:0] d;
    int r, b;
    r = j / 2;
    b = j % 2;
    for (int k = 0; k < 4; k++) d[k*8 +: 8] = 8'(r*8 + b*4 + k + off);
    return d;
  endfunction

  function automatic logic [63:0] row_exp(input int r, input int off);
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[c*8 +: 8] = 8'(r*8 + c + off);
    return v;
  endfunction

  // Expected cycle-by-cycle behaviour from the beat schedule.
  task automatic build(input bit noisy);
    int t, j, tl;
    for (int i = 0; i < 64; i++) tbl[i] = '{default: '0};
    tbl[0].start = 1'b1;
    tbl[0].valid = noisy;
    j = 0;
    t = 1;
    while (j < 16) begin
      tbl[t].rdy = 1'b1;
      tbl[t].busy = 1'b1;
      if (!bmask[t]) begin
        tbl[t].valid = 1'b1;
        tbl[t].data = beat_data(j, 0);
        if (j % 2 == 1) begin
          tbl[t+1].wr = 1'b1;
          tbl[t+1].arow = 3'(j / 2);
        end
        j++;
      end
      t++;
    end
    tl = t - 1;
    for (int c = tl + 1; c <= tl + 17; c++) tbl[c].busy = 1'b1;
    for (int c = tl + 2; c <= tl + 16; c++) tbl[c].en = 1'b1;
    tbl[tl+17].done = 1'b1;
    if (noisy) begin
      for (int c = tl + 1; c <= tl + 19; c++) begin
        tbl[c].valid = 1'b1;
        tbl[c].data = 32'hdeadbeef;
      end
      for (int c = tl + 2; c <= tl + 9; c++) tbl[c].start = 1'(c % 2);
    end
    ntbl = tl + 20;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < ntbl; i++) begin
      @(posedge clk);
      #1;
      start = tbl[i].start;
      in_valid = tbl[i].valid;
      in_data = tbl[i].data;
      @(negedge clk);
      chk({tag, "_rdy"}, 64'(in_ready), 64'(tbl[i].rdy));
      chk({tag, "_wren"}, 64'(wren), 64'(tbl[i].wr));
      chk({tag, "_en"}, 64'(en), 64'(tbl[i].en));
      chk({tag, "_done"}, 64'(done), 64'(tbl[i].done));
      chk({tag, "_busy"}, 64'(busy), 64'(tbl[i].busy));
      if (tbl[i].wr) begin
        chk({tag, "_arow"}, 64'(arow), 64'(tbl[i].arow));
        chk({tag, "_ain"}, ain, row_exp(int'(tbl[i].arow), 0));
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
  endtask

  task automatic feed_rows(input int nbeats, input int off,
                           input bit abort_last);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int j = 0; j < nbeats; j++) begin
      in_valid = 1'b1;
      in_data = beat_data(j, off);
      abort = abort_last && (j == nbeats - 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int cnt, dn;
    bit seen;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      start = 1'($urandom);
      abort = 1'($urandom);
      in_valid = 1'($urandom);
      in_data = $urandom;
    end
    @(negedge clk);
    chk("rst_rdy", 64'(in_ready), 0);
    chk("rst_wren", 64'(wren), 0);
    chk("rst_en", 64'(en), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_arow", 64'(arow), 0);
    chk("rst_ain", ain, 0);
    chk("rst_bub", 64'(bubble_cnt), 0);
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h01020304;
    rst_n = 1'b1;

    // Idle with in_valid high: nothing must move
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cnt += int'(busy) + int'(wren) + int'(en) + int'(in_ready);
    end
    chk("idle_quiet", 64'(cnt), 0);
    in_valid = 1'b0;

    // Full-rate load
    for (int i = 0; i < 64; i++) bmask[i] = 1'b0;
    build(1'b0);
    run_table("full");
    chk("full_bub", 64'(bubble_cnt), 0);

    // Abort together with row 3's final beat
    feed_rows(8, 100, 1'b1);
    @(negedge clk);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_wren", 64'(wren), 0);
    chk("abort_rdy", 64'(in_ready), 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt += int'(wren) + int'(en) + int'(done) + int'(busy);
    end
    chk("abort_quiet", 64'(cnt), 0);

    // Bubbled, noisy load after the abort: restarts at row 0
    bmask[2] = 1'b1;
    bmask[5] = 1'b1;
    bmask[6] = 1'b1;
    bmask[11] = 1'b1;
    bmask[15] = 1'b1;
    build(1'b1);
    run_table("bub");
    chk("bub_cnt", 64'(bubble_cnt), 64'(BUB_EXP));

    // Async reset in the middle of DRAIN
    feed_rows(16, 0, 1'b0);
    seen = 1'b0;
    dn = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      dn += int'(done);
      if (en) seen = 1'b1;
    end
    chk("drain_start", 64'(seen), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk("pre_rst_en", 64'(en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", 64'(en), 0);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_wren", 64'(wren), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      dn += int'(done) + int'(busy) + int'(en);
    end
    chk("arst_nodone", 64'(dn), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
